exe_mult_accum: RTL
===================

// Module: exe_mult_accum
// PURPOSE
//  Radix-16 iterative accumulate/finish stage of the RV64M multiplier datapath.
//  - Consumes the 16-entry multiples table (0..15 x rs1) from the multiples-generation stage, plus rs1, rs2 and the op select.
//  - Accumulates one multiplier nibble per cycle, applies the signed-operand correction, and returns the XLEN-bit rd result to writeback.
// PARAMETERS
//  XLEN  64  operand/result width (maverickOne_pkg::XLEN); must be a multiple of 4
//  W     XLEN+4 (localparam)  width of one table entry, unsigned k*rs1
// PORTS
//  clk_i       in   1       clock, rising edge
//  arst_i      in   1       asynchronous reset, active-high
//  clear_i     in   1       synchronous flush: abort the op, return to IDLE
//  valid_i     in   1       table + operands + op valid
//  ready_o     out  1       stage can accept a new op
//  MUL_i       in   1       op select: MUL (low XLEN of product)
//  MULH_i      in   1       op select: MULH (high XLEN, signed x signed)
//  MULHSU_i    in   1       op select: MULHSU (high XLEN, signed rs1 x unsigned rs2)
//  MULHU_i     in   1       op select: MULHU (high XLEN, unsigned x unsigned)
//  MULW_i      in   1       op select: MULW (low 32 bits, sign-extended)
//  rs1_i       in   XLEN    multiplicand, raw bits
//  rs2_i       in   XLEN    multiplier, raw bits
//  multiples_i in   16*W    entry k = k*rs1 (unsigned), at bits [(15-k)*W +: W]; entry 0 at MSB
//  valid_o     out  1       rd_o valid
//  ready_i     in   1       writeback accepts rd_o
//  rd_o        out  XLEN    result
// BEHAVIOUR
//  Reset: async on arst_i high. state=IDLE, ready_o=1, valid_o=0, rd_o=0, accumulator and counter = 0.
//  Accept: handshake when valid_i & ready_o & (any op flag).
//   - Capture the table, rs1, rs2 and op.
//   - valid_i with no op flag set is ignored (not accepted).
//  Op flags: exactly one is high by contract. If several are high, priority is MULW > MULHU > MULHSU > MULH > MUL.
//  FSM:
//   - IDLE -> ACCUM on accept; counter=0, acc=0.
//   - ACCUM: each cycle nib = rs2[4*i +: 4] and acc += multiples[nib] << 4*i, with acc 2*XLEN bits, mod 2^(2*XLEN).
//     Runs N = XLEN/4 cycles (N=8 for MULW, using rs2[31:0] only), then -> FIX.
//   - FIX (1 cycle), signed correction mod 2^(2*XLEN):
//     MULH: acc -= (rs1[XLEN-1] ? rs2<<XLEN : 0) + (rs2[XLEN-1] ? rs1<<XLEN : 0).
//     MULHSU: acc -= (rs1[XLEN-1] ? rs2<<XLEN : 0).
//     MUL, MULHU, MULW: no correction.
//     Then register rd_o and -> DONE.
//   - rd_o select: MUL = acc[XLEN-1:0]; MULH/MULHSU/MULHU = acc[2*XLEN-1:XLEN]; MULW = sext(acc[31:0]).
//   - DONE: valid_o=1. rd_o is held stable until ready_i; on valid_o & ready_i -> IDLE.
//  ready_o is 1 only in IDLE (no overlap). Back-to-back accept is possible in the cycle after a DONE handshake.
//  Latency from accept edge to valid_o: N+1 cycles (XLEN=64: 17 cycles, MULW: 9 cycles).
//  Back-pressure: DONE holds indefinitely. valid_o, once high, never drops without ready_i, except on arst_i/clear_i.
//  clear_i takes priority over every transition.
//   - Next state is IDLE, valid_o=0, and any in-flight result is discarded.
//   - A valid_i presented in the same cycle as clear_i is not accepted.
//  Reset mid-op (ACCUM/FIX/DONE): immediate return to reset values. No result is emitted after reset release.
//  Operand/table changes on the inputs after accept have no effect (captured copies are used).
//  Zero operands still take the full N cycles (no early termination).
// TESTING
//  1. MUL rs1=3, rs2=5 -> valid_o after 17 cycles, rd_o=0xF.
//  2. MULH rs1=rs2=0xFFFF_FFFF_FFFF_FFFF (-1 x -1) -> rd_o=0x0. MULHU same operands -> rd_o=0xFFFF_FFFF_FFFF_FFFE.
//  3. MULHSU rs1=0xFFFF_FFFF_FFFF_FFFF (-1), rs2=2 -> rd_o=0xFFFF_FFFF_FFFF_FFFF. MULH rs1=2^63, rs2=2^63 -> rd_o=0x4000_0000_0000_0000.
//  4. MULW rs1=0x7FFF_FFFF, rs2=2 -> valid_o after 9 cycles, rd_o=0xFFFF_FFFF_FFFF_FFFE.
//     Upper rs2 bits set (rs2=0xABCD_0000_0000_0002) -> same result.
//  5. ready_i low for 5 cycles in DONE -> valid_o and rd_o stable. ready_o=0 throughout; a new valid_i is not accepted until after the handshake.
//  6. arst_i pulse at ACCUM cycle 6, and separately clear_i in FIX -> IDLE, valid_o=0, no stale result.
//     Next MUL 7*9 -> rd_o=0x3F.

Source files
------------

// File: rtl/exe_mult_accum.sv
// Radix-16 iterative accumulate/finish stage of the RV64M multiplier.
// Adds one table-selected partial product per multiplier nibble, then applies signed correction.
module exe_mult_accum #(
  parameter int XLEN = 64
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     MUL_i,
  input  logic                     MULH_i,
  input  logic                     MULHSU_i,
  input  logic                     MULHU_i,
  input  logic                     MULW_i,
  input  logic [XLEN-1:0]          rs1_i,
  input  logic [XLEN-1:0]          rs2_i,
  input  logic [16*(XLEN+4)-1:0]   multiples_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          rd_o
);

  localparam int W  = XLEN + 4;
  localparam int N  = XLEN / 4;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ACCUM, FIX, DONE} state_t;
  typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW} op_t;

  state_t state, state_n;
  op_t    op_sel, op_q;

  // Ascending range puts entry 0 at the MSB, so tbl_q[k] == k*rs1.
  logic [0:15][W-1:0]  tbl_q;
  logic [XLEN-1:0]     rs1_q, rs2_q;
  logic [2*XLEN-1:0]   acc, pp, corr, fixed;
  logic [CW-1:0]       cnt, last_cnt;
  logic [3:0]          nib;
  logic [XLEN-1:0]     rd_d;
  logic                any_op, accept, last;

  assign any_op  = MUL_i | MULH_i | MULHSU_i | MULHU_i | MULW_i;
  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign accept  = ready_o & valid_i & any_op & ~clear_i;

  always_comb begin
    op_sel = OP_MUL;
    if      (MULW_i)   op_sel = OP_MULW;
    else if (MULHU_i)  op_sel = OP_MULHU;
    else if (MULHSU_i) op_sel = OP_MULHSU;
    else if (MULH_i)   op_sel = OP_MULH;
  end

  // MULW only walks the low 32 bits of rs2.
  assign last_cnt = (op_q == OP_MULW) ? CW'(7) : CW'(N - 1);
  assign last     = (cnt == last_cnt);
  assign nib      = rs2_q[{cnt, 2'b00} +: 4];
  assign pp       = {{(XLEN-4){1'b0}}, tbl_q[nib]} << {cnt, 2'b00};

  always_comb begin
    corr = '0;
    if ((op_q == OP_MULH || op_q == OP_MULHSU) && rs1_q[XLEN-1])
      corr = corr + {rs2_q, {XLEN{1'b0}}};
    if (op_q == OP_MULH && rs2_q[XLEN-1])
      corr = corr + {rs1_q, {XLEN{1'b0}}};
    fixed = acc - corr;
  end

  always_comb begin
    unique case (op_q)
      OP_MUL:  rd_d = fixed[XLEN-1:0];
      OP_MULW: rd_d = {{(XLEN-32){fixed[31]}}, fixed[31:0]};
      default: rd_d = fixed[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = ACCUM;
      ACCUM:   if (last)   state_n = FIX;
      FIX:                 state_n = DONE;
      DONE:    if (ready_i) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
    if (clear_i) state_n = IDLE;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tbl_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      op_q  <= OP_MUL;
      acc   <= '0;
      cnt   <= '0;
      rd_o  <= '0;
    end else if (clear_i) begin
      acc   <= '0;
      cnt   <= '0;
      rd_o  <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          tbl_q <= multiples_i;
          rs1_q <= rs1_i;
          rs2_q <= rs2_i;
          op_q  <= op_sel;
          acc   <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          acc <= acc + pp;
          cnt <= cnt + CW'(1);
        end
        FIX:     rd_o <= rd_d;
        default: ;
      endcase
    end
  end

endmodule
